// File: rtl/control_unit_pkg.sv
// ============================================================================
// Module   : control_unit_pkg
// Purpose  : Opcode constants, ALU select encodings and EX-stage bubble.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package control_unit_pkg;

    localparam int unsigned c_xlen = 32;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_sel_e;

    typedef struct packed {
        logic [4:0]        rd;
        logic [c_xlen-1:0] result;
        logic [c_xlen-1:0] store_data;
        logic [c_xlen-1:0] link;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              jump;
        logic              branch_taken;
    } ex_reg_t;

    localparam ex_reg_t c_bubble = '0;

    // Register-register and register-immediate ops share the funct3 map;
    // only R-type may turn add into sub.
    function automatic alu_sel_e funct3_to_alu(input logic [2:0] funct3,
                                               input logic       is_r,
                                               input logic       funct7_b5);
        alu_sel_e sel;
        case (funct3)
            3'b000:  sel = (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b010:  sel = ALU_SLT;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = ALU_SRL;
            3'b110:  sel = ALU_OR;
            3'b111:  sel = ALU_AND;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit_alu_core.sv
// ============================================================================
// Module   : alu_core
// Purpose  : Combinational 32-bit ALU for the EX stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core
    import control_unit_pkg::*;
(
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  alu_sel_e    alu_sel,
    output logic [31:0] result
);

    logic [4:0] w_shamt;

    assign w_shamt = operand2[4:0];

    always_comb begin
        result = '0;
        case (alu_sel)
            ALU_ADD: result = operand1 + operand2;
            ALU_SUB: result = operand1 - operand2;
            ALU_AND: result = operand1 & operand2;
            ALU_OR:  result = operand1 | operand2;
            ALU_XOR: result = operand1 ^ operand2;
            ALU_SLL: result = operand1 << w_shamt;
            ALU_SRL: result = operand1 >> w_shamt;
            ALU_SLT: result = {31'b0, ($signed(operand1) < $signed(operand2))};
            default: result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module   : control_unit
// Purpose  : RV32 subset decode/execute with a single registered EX stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit
    import control_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_result,
    output logic [31:0] ex_store_data,
    output logic [31:0] ex_link,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_jump,
    output logic        ex_branch_taken
);

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;

    logic [31:0] w_operand1;
    logic [31:0] w_operand2;
    alu_sel_e    w_alu_sel;
    logic [31:0] w_alu_result;
    logic        w_valid;
    logic        w_reg_write;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_jump;
    logic        w_branch_taken;
    ex_reg_t     w_next;
    ex_reg_t     r_ex;

    assign w_opcode = instruction[6:0];
    assign w_rd     = instruction[11:7];
    assign w_funct3 = instruction[14:12];
    assign w_funct7 = instruction[31:25];
    assign rs1      = instruction[19:15];
    assign rs2      = instruction[24:20];

    assign w_imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign w_imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign w_imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
    assign w_imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};

    always_comb begin
        w_operand1     = rs1_data;
        w_operand2     = rs2_data;
        w_alu_sel      = ALU_ADD;
        w_valid        = 1'b0;
        w_reg_write    = 1'b0;
        w_mem_read     = 1'b0;
        w_mem_write    = 1'b0;
        w_jump         = 1'b0;
        w_branch_taken = 1'b0;
        case (w_opcode)
            c_op_r: begin
                w_valid     = 1'b1;
                w_reg_write = 1'b1;
                w_alu_sel   = funct3_to_alu(w_funct3, 1'b1, w_funct7[5]);
            end
            c_op_i: begin
                w_valid     = 1'b1;
                w_reg_write = 1'b1;
                w_operand2  = w_imm_i;
                w_alu_sel   = funct3_to_alu(w_funct3, 1'b0, w_funct7[5]);
            end
            c_op_load: begin
                w_valid     = 1'b1;
                w_reg_write = 1'b1;
                w_mem_read  = 1'b1;
                w_operand2  = w_imm_i;
            end
            c_op_store: begin
                w_valid     = 1'b1;
                w_mem_write = 1'b1;
                w_operand2  = w_imm_s;
            end
            c_op_branch: begin
                w_valid        = 1'b1;
                w_operand1     = pc;
                w_operand2     = w_imm_b;
                // Only BEQ is resolved here; other branch kinds fall through.
                w_branch_taken = (w_funct3 == 3'b000) && (rs1_data == rs2_data);
            end
            c_op_jal: begin
                w_valid     = 1'b1;
                w_reg_write = 1'b1;
                w_jump      = 1'b1;
                w_operand1  = pc;
                w_operand2  = w_imm_j;
            end
            default: w_valid = 1'b0;
        endcase
    end

    alu_core u_alu_core (
        .operand1 (w_operand1),
        .operand2 (w_operand2),
        .alu_sel  (w_alu_sel),
        .result   (w_alu_result)
    );

    always_comb begin
        w_next = c_bubble;
        if (w_valid) begin
            w_next.rd           = w_rd;
            w_next.result       = w_alu_result;
            w_next.store_data   = rs2_data;
            w_next.link         = pc + 32'd4;
            w_next.reg_write    = w_reg_write && (w_rd != 5'd0);
            w_next.mem_read     = w_mem_read;
            w_next.mem_write    = w_mem_write;
            w_next.jump         = w_jump;
            w_next.branch_taken = w_branch_taken;
        end
    end

    // Flush takes priority over stall so a squashed slot never lingers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex <= c_bubble;
        end else if (flush) begin
            r_ex <= c_bubble;
        end else if (!stall) begin
            r_ex <= w_next;
        end
    end

    assign ex_rd           = r_ex.rd;
    assign ex_result       = r_ex.result;
    assign ex_store_data   = r_ex.store_data;
    assign ex_link         = r_ex.link;
    assign ex_reg_write    = r_ex.reg_write;
    assign ex_mem_read     = r_ex.mem_read;
    assign ex_mem_write    = r_ex.mem_write;
    assign ex_jump         = r_ex.jump;
    assign ex_branch_taken = r_ex.branch_taken;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module   : tb_control_unit
// Purpose  : Directed self-checking bench for control_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [31:0] ex_link;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_jump;
    logic        ex_branch_taken;

    int n_tests = 0;
    int n_fail  = 0;

    control_unit dut (
        .clk             (clk),
        .rst             (rst),
        .instruction     (instruction),
        .pc              (pc),
        .stall           (stall),
        .flush           (flush),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .rs1             (rs1),
        .rs2             (rs2),
        .ex_rd           (ex_rd),
        .ex_result       (ex_result),
        .ex_store_data   (ex_store_data),
        .ex_link         (ex_link),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_jump         (ex_jump),
        .ex_branch_taken (ex_branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one decode slot, let one rising edge pass, then settle past it.
    task automatic step(input logic [31:0] inst, input logic [31:0] p,
                        input logic [31:0] d1, input logic [31:0] d2);
        instruction = inst;
        pc          = p;
        rs1_data    = d1;
        rs2_data    = d2;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd"},   {27'b0, ex_rd}, 32'h0);
        check({tag, "_res"},  ex_result, 32'h0);
        check({tag, "_sd"},   ex_store_data, 32'h0);
        check({tag, "_link"}, ex_link, 32'h0);
        check({tag, "_ctl"},  {27'b0, ex_reg_write, ex_mem_read, ex_mem_write,
                               ex_jump, ex_branch_taken}, 32'h0);
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        flush       = 1'b0;
        instruction = 32'h002081B3;
        pc          = 32'h0;
        rs1_data    = 32'd5;
        rs2_data    = 32'd7;

        #3;
        check_all_zero("reset_async");
        @(posedge clk); #1;
        check_all_zero("reset_held_edge");
        check("rs1_field", {27'b0, rs1}, 32'd1);
        check("rs2_field", {27'b0, rs2}, 32'd2);
        rst = 1'b0;

        // ADD x3,x1,x2 on the first edge after reset release
        step(32'h002081B3, 32'h0, 32'd5, 32'd7);
        check("add_res", ex_result, 32'd12);
        check("add_rd", {27'b0, ex_rd}, 32'd3);
        check("add_rw", {31'b0, ex_reg_write}, 32'd1);
        check("add_sd", ex_store_data, 32'd7);
        check("add_link", ex_link, 32'd4);

        step(32'h402081B3, 32'h4, 32'd5, 32'd7);
        check("sub_res", ex_result, 32'hFFFFFFFE);

        step(32'hFFF00093, 32'h8, 32'd0, 32'd0);
        check("addi_res", ex_result, 32'hFFFFFFFF);
        check("addi_rw", {31'b0, ex_reg_write}, 32'd1);
        check("addi_rd", {27'b0, ex_rd}, 32'd1);

        step(32'h0020A423, 32'hC, 32'h100, 32'hAB);
        check("sw_res", ex_result, 32'h108);
        check("sw_sd", ex_store_data, 32'hAB);
        check("sw_mw", {31'b0, ex_mem_write}, 32'd1);
        check("sw_rw", {31'b0, ex_reg_write}, 32'd0);

        step(32'h00208863, 32'h40, 32'd9, 32'd9);
        check("beq_eq_res", ex_result, 32'h50);
        check("beq_eq_tk", {31'b0, ex_branch_taken}, 32'd1);
        check("beq_eq_rw", {31'b0, ex_reg_write}, 32'd0);

        step(32'h00208863, 32'h40, 32'd9, 32'd8);
        check("beq_ne_tk", {31'b0, ex_branch_taken}, 32'd0);

        // LW x4,12(x1)
        step(32'h00C0A203, 32'h50, 32'h200, 32'h0);
        check("lw_res", ex_result, 32'h20C);
        check("lw_mr", {31'b0, ex_mem_read}, 32'd1);
        check("lw_rw", {31'b0, ex_reg_write}, 32'd1);

        // SLLI x5,x1,4
        step(32'h00409293, 32'h54, 32'd3, 32'h0);
        check("slli_res", ex_result, 32'h30);

        // SLT x3,x1,x2 with -1 < 1
        step(32'h0020A1B3, 32'h58, 32'hFFFFFFFF, 32'd1);
        check("slt_res", ex_result, 32'd1);

        // ADDI x0,x0,5: result computed, write suppressed
        step(32'h00500013, 32'h5C, 32'd0, 32'd0);
        check("x0_res", ex_result, 32'd5);
        check("x0_rw", {31'b0, ex_reg_write}, 32'd0);

        // LUI is outside the supported set
        step(32'h12345037, 32'h60, 32'd1, 32'd2);
        check_all_zero("unsupported");

        // JAL x1,+8
        step(32'h008000EF, 32'h20, 32'd0, 32'd0);
        check("jal_res", ex_result, 32'h28);
        check("jal_link", ex_link, 32'h24);
        check("jal_jump", {31'b0, ex_jump}, 32'd1);
        check("jal_rw", {31'b0, ex_reg_write}, 32'd1);

        stall = 1'b1;
        step(32'h002081B3, 32'h0, 32'd5, 32'd7);
        check("stall_res", ex_result, 32'h28);
        check("stall_jump", {31'b0, ex_jump}, 32'd1);

        flush = 1'b1;
        step(32'h002081B3, 32'h0, 32'd5, 32'd7);
        check_all_zero("flush_stall");
        stall = 1'b0;
        flush = 1'b0;

        step(32'h008000EF, 32'h20, 32'd0, 32'd0);
        check("jal2_res", ex_result, 32'h28);

        // Reset mid-cycle, well before the next rising edge
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid");
        stall = 1'b1;
        @(posedge clk); #1;
        check_all_zero("reset_vs_stall");
        stall = 1'b0;
        rst   = 1'b0;

        step(32'h002081B3, 32'h0, 32'd5, 32'd7);
        check("post_rst_res", ex_result, 32'd12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
